// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes RxD, samples each bit at mid-period and holds
// the received byte in a one-entry register with a valid/read handshake.
module uart_receiver #(
   parameter int baud_rate_count = 108
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RxD,
   input  logic       rd,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam logic [13:0] BaudCnt = 14'(baud_rate_count);
   localparam logic [13:0] HalfCnt = 14'(baud_rate_count >> 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state_q;
   logic        rxdSync1_q;
   logic        rxdSync_q;
   logic        rxdDly_q;
   logic [13:0] counter_q;
   logic [2:0]  bitCnt_q;
   logic [7:0]  shiftReg_q;
   logic [7:0]  data_q;
   logic        valid_q;
   logic        frameErr_q;
   logic        overrun_q;
   logic        loadAllowed;

   // Sync flops idle at 1 so a line already low at reset release reads as an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxdSync1_q <= 1'b1;
         rxdSync_q  <= 1'b1;
         rxdDly_q   <= 1'b1;
      end else begin
         rxdSync1_q <= RxD;
         rxdSync_q  <= rxdSync1_q;
         rxdDly_q   <= rxdSync_q;
      end
   end

   assign loadAllowed = !valid_q || rd;

   // A load later in this block overrides the read-clear of valid above it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         counter_q  <= '0;
         bitCnt_q   <= '0;
         shiftReg_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         frameErr_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         frameErr_q <= 1'b0;
         if (rd && valid_q) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               counter_q <= '0;
               if (!rxdSync_q && rxdDly_q) begin
                  state_q <= START;
               end
            end
            START: begin
               if (counter_q == HalfCnt) begin
                  counter_q <= '0;
                  if (!rxdSync_q) begin
                     state_q  <= DATA;
                     bitCnt_q <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  counter_q <= counter_q + 14'd1;
               end
            end
            DATA: begin
               if (counter_q == BaudCnt) begin
                  counter_q  <= '0;
                  shiftReg_q <= {rxdSync_q, shiftReg_q[7:1]};
                  bitCnt_q   <= bitCnt_q + 3'd1;
                  if (bitCnt_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  counter_q <= counter_q + 14'd1;
               end
            end
            STOP: begin
               if (counter_q == BaudCnt) begin
                  counter_q <= '0;
                  state_q   <= IDLE;
                  if (rxdSync_q) begin
                     if (loadAllowed) begin
                        data_q  <= shiftReg_q;
                        valid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else begin
                     frameErr_q <= 1'b1;
                  end
               end else begin
                  counter_q <= counter_q + 14'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frameErr_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at a 16-cycle bit period; expected
// bytes are queued as frames are sent and compared when valid appears.
module tb_uart_receiver;

   localparam int Baud = 15;
   localparam int P    = Baud + 1;

   logic       clk;
   logic       rst;
   logic       RxD;
   logic       rd;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   int         cycle = 0;
   int         t0 = 0;
   int         feCount = 0;
   int         feWide = 0;
   bit         feLast = 0;
   bit         overrunSeen = 0;
   bit         busySeen = 0;
   logic [7:0] expQ[$];

   uart_receiver #(.baud_rate_count(Baud)) dut (
      .clk       (clk),
      .rst       (rst),
      .RxD       (RxD),
      .rd        (rd),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   // Passive observers for pulse width and sticky events between checks.
   always @(negedge clk) begin
      if (frame_err) feCount++;
      if (frame_err && feLast) feWide++;
      feLast = frame_err;
      if (overrun) overrunSeen = 1;
      if (busy) busySeen = 1;
   end

   // Caller must be 1 time unit after a rising edge; T0 is the next edge.
   task automatic sendByte(input logic [7:0] b, input logic stopBit, input bit expectLoad);
      logic [9:0] frame;
      frame = {stopBit, b, 1'b0};
      if (expectLoad) expQ.push_back(b);
      t0 = cycle + 1;
      for (int k = 0; k < 10; k++) begin
         RxD = frame[k];
         repeat (P) begin
            @(posedge clk);
            #1;
         end
      end
      RxD = 1'b1;
   endtask

   task automatic waitValid(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (valid) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic popExp(output logic [7:0] e, output bit ok);
      ok = (expQ.size() > 0);
      e  = 8'h00;
      if (ok) e = expQ.pop_front();
   endtask

   task automatic pulseRd();
      @(posedge clk);
      #1 rd = 1'b1;
      @(posedge clk);
      #1 rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks += 5;
      if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", data); end
      if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
      if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err got %b want 0", frame_err); end
      if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
   endtask

   task automatic test_single();
      bit ok, qok;
      logic [7:0] e;
      int seenAt;
      @(posedge clk);
      #1;
      feCount = 0;
      fork
         sendByte(8'hA5, 1'b1, 1'b1);
         begin
            waitValid(400, ok);
            seenAt = cycle;
         end
      join
      popExp(e, qok);
      checks += 4;
      if (!ok || !qok || data !== e) begin
         errors++; $display("[TB] FAIL single_data got %h valid_seen %0d want %h", data, ok, e);
      end
      if (seenAt !== t0 + 154) begin
         errors++; $display("[TB] FAIL single_timing got edge T0+%0d want T0+154", seenAt - t0);
      end
      if (feCount !== 0) begin errors++; $display("[TB] FAIL single_frame_err got %0d pulses want 0", feCount); end
      pulseRd();
      if (valid !== 1'b0) begin errors++; $display("[TB] FAIL single_rd_clear got %b want 0", valid); end
   endtask

   // Checks busy at the load edge separately so it lines up with the valid edge.
   task automatic test_busy_at_load();
      bit ok;
      logic [7:0] e;
      bit qok;
      @(posedge clk);
      #1;
      fork
         sendByte(8'h6E, 1'b1, 1'b1);
         waitValid(400, ok);
      join_any
      checks += 2;
      if (!ok || busy !== 1'b0) begin errors++; $display("[TB] FAIL load_busy got %b want 0", busy); end
      wait fork;
      popExp(e, qok);
      if (!qok || data !== e) begin errors++; $display("[TB] FAIL load_data got %h want %h", data, e); end
      pulseRd();
   endtask

   task automatic test_back_to_back();
      bit ok, qok;
      logic [7:0] e;
      @(posedge clk);
      #1;
      overrunSeen = 0;
      fork
         begin
            sendByte(8'h3C, 1'b1, 1'b1);
            sendByte(8'hC3, 1'b1, 1'b1);
         end
         begin
            for (int n = 0; n < 2; n++) begin
               waitValid(400, ok);
               popExp(e, qok);
               checks += 2;
               if (!ok || !qok || data !== e) begin
                  errors++; $display("[TB] FAIL b2b_data%0d got %h want %h", n, data, e);
               end
               pulseRd();
               if (valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rd_clear%0d got %b want 0", n, valid); end
            end
         end
      join
      checks++;
      if (overrunSeen !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun got %b want 0", overrunSeen); end
   endtask

   task automatic test_overrun();
      bit qok;
      logic [7:0] e;
      @(posedge clk);
      #1;
      sendByte(8'h11, 1'b1, 1'b1);
      sendByte(8'h22, 1'b1, 1'b0);
      @(negedge clk);
      popExp(e, qok);
      checks += 3;
      if (valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid got %b want 1", valid); end
      if (!qok || data !== e) begin errors++; $display("[TB] FAIL ovr_data got %h want %h", data, e); end
      if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag got %b want 1", overrun); end
      pulseRd();
      checks += 2;
      if (valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_rd_valid got %b want 0", valid); end
      if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_rd_flag got %b want 0", overrun); end
   endtask

   task automatic test_frame_error();
      bit ok, qok;
      logic [7:0] e;
      @(posedge clk);
      #1;
      feCount = 0;
      feWide = 0;
      sendByte(8'h5A, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      checks += 3;
      if (feCount !== 1) begin errors++; $display("[TB] FAIL fe_count got %0d want 1", feCount); end
      if (feWide !== 0) begin errors++; $display("[TB] FAIL fe_width got %0d extra cycles want 0", feWide); end
      if (valid !== 1'b0) begin errors++; $display("[TB] FAIL fe_valid got %b want 0", valid); end
      fork
         sendByte(8'h81, 1'b1, 1'b1);
         waitValid(400, ok);
      join
      popExp(e, qok);
      checks++;
      if (!ok || !qok || data !== e) begin errors++; $display("[TB] FAIL fe_next_data got %h want %h", data, e); end
      pulseRd();
   endtask

   task automatic test_glitch();
      @(posedge clk);
      #1;
      busySeen = 0;
      feCount = 0;
      RxD = 1'b0;
      repeat (4) @(posedge clk);
      #1 RxD = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (busySeen !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_seen got %b want 1", busySeen); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_end got %b want 0", busy); end
      if (valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid got %b want 0", valid); end
      if (feCount !== 0) begin errors++; $display("[TB] FAIL glitch_frame_err got %0d want 0", feCount); end
   endtask

   task automatic test_reset_mid_frame();
      bit qok;
      logic [7:0] e;
      @(posedge clk);
      #1;
      fork
         sendByte(8'hFF, 1'b1, 1'b0);
         begin
            repeat (60) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            checks += 5;
            if (data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_data got %h want 00", data); end
            if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %b want 0", valid); end
            if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_fe got %b want 0", frame_err); end
            if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_overrun got %b want 0", overrun); end
            if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
         end
      join
      repeat (5) @(posedge clk);
      #1;
      sendByte(8'h99, 1'b1, 1'b1);
      @(negedge clk);
      popExp(e, qok);
      checks++;
      if (valid !== 1'b1 || !qok || data !== e) begin
         errors++; $display("[TB] FAIL rstmid_first got %h valid %b want %h", data, valid, e);
      end
      @(posedge clk);
      #1;
      fork
         sendByte(8'h0F, 1'b1, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1 rd = 1'b1;
            @(posedge clk);
            #1 rd = 1'b0;
         end
      join
      @(negedge clk);
      popExp(e, qok);
      checks += 3;
      if (valid !== 1'b1) begin errors++; $display("[TB] FAIL rd_load_valid got %b want 1", valid); end
      if (!qok || data !== e) begin errors++; $display("[TB] FAIL rd_load_data got %h want %h", data, e); end
      if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL rd_load_overrun got %b want 0", overrun); end
   endtask

   initial begin
      rst = 1'b1;
      RxD = 1'b1;
      rd  = 1'b0;
      test_reset();
      test_single();
      test_busy_at_load();
      test_back_to_back();
      test_overrun();
      test_frame_error();
      test_glitch();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case a wait never resolves.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
